// File: rtl/reg_apb2native_pkg.sv
// reg_apb2native_pkg: shared FSM state type and default timeout for the APB-to-native register bridge
package reg_apb2native_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/reg_apb2native_wdt.sv
// reg_apb2native_wdt: native ack watchdog for the APB-to-native bridge
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : clears the count (the cycle the command is captured)
//   run        : high while a native request is outstanding (REQ/WAIT)
//   ack        : native acknowledge, stops the count for this cycle
//   expired    : TIMEOUT_CYCLES request cycles have passed without an ack
module reg_apb2native_wdt
    import reg_apb2native_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (start)
            cnt <= '0;
        else if (run && !ack)
            cnt <= cnt + CW'(1);
    end

    // The REQ cycle is counted as cycle 0, so the last ackless cycle is TIMEOUT_CYCLES-1.
    assign expired = run && !ack && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/reg_apb2native_if.sv
// reg_apb2native_if: APB3 completer issuing single native-interface register transactions
//   clk, rst_n                         : clock, asynchronous active-low reset
//   psel, penable, pwrite, paddr, pwdata : APB request
//   pready, prdata, pslverr            : APB response (one-cycle pready, registered data/error)
//   req_vld, wr_en, rd_en, addr, wr_data : native command (req_vld is a one-cycle pulse)
//   ack_vld, rd_data, err              : native response (data/error valid with ack_vld)
//   Macro REG_APB2NATIVE_TIMEOUT_EN adds a watchdog that completes the transfer with
//   pslverr=1 when no ack arrives within TIMEOUT_CYCLES cycles of the request.
module reg_apb2native_if
    import reg_apb2native_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 48,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    output logic                  pready,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  req_vld,
    input  logic                  ack_vld,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state, state_nxt;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  slverr_q;
    logic                  setup;
    logic                  busy;
    logic                  expired;

    // Only a setup phase seen in IDLE starts a transfer; an access phase without one is ignored.
    assign setup = (state == IDLE) && psel && !penable;
    assign busy  = (state == REQ) || (state == WAIT);

`ifdef REG_APB2NATIVE_TIMEOUT_EN
    reg_apb2native_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (setup),
        .run    (busy),
        .ack    (ack_vld),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    // psel/penable are not watched once the command is captured: the native side always completes.
    always_comb begin
        state_nxt = (state == IDLE)          ? (setup ? REQ : IDLE) :
                    (state == RESP)          ? IDLE :
                    (ack_vld || expired)     ? RESP : WAIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (setup) begin
                cmd_wr    <= pwrite;
                cmd_addr  <= paddr;
                cmd_wdata <= pwdata;
            end
            if (state == RESP) begin
                rdata_q  <= '0;
                slverr_q <= 1'b0;
            end else if (busy && ack_vld) begin
                rdata_q  <= cmd_wr ? '0 : rd_data;
                slverr_q <= err;
            end else if (expired) begin
                rdata_q  <= '0;
                slverr_q <= 1'b1;
            end
        end
    end

    // All outputs decode from registered state so they are glitch-free and zero outside a transfer.
    assign pready  = (state == RESP);
    assign prdata  = rdata_q;
    assign pslverr = slverr_q;
    assign req_vld = (state == REQ);
    assign wr_en   = busy && cmd_wr;
    assign rd_en   = busy && !cmd_wr;
    assign addr    = busy ? cmd_addr : '0;
    assign wr_data = busy ? cmd_wdata : '0;

endmodule

// File: tb/tb_reg_apb2native_if.sv
// tb_reg_apb2native_if: self-checking bench for the APB-to-native register bridge
module tb_reg_apb2native_if;

    localparam int AW = 48;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr, addr;
    logic [DW-1:0] pwdata, prdata, wr_data, rd_data;
    logic          req_vld, ack_vld, wr_en, rd_en, err;

    always #5 clk = ~clk;

    reg_apb2native_if #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .psel   (psel),
        .penable(penable),
        .pready (pready),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pslverr(pslverr),
        .req_vld(req_vld),
        .ack_vld(ack_vld),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .err    (err)
    );

    // dly: cycles from the req_vld cycle to the ack (negative = never ack)
    // gap: idle cycles before the setup phase; drop: psel/penable fall after the first access cycle
    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            dly;
        logic [DW-1:0] rd;
        logic          e;
        int            gap;
        logic          drop;
        logic [DW-1:0] x_pr;
        logic          x_err;
        int            x_cyc;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    // Transaction-level expectation: reads return the acked word, writes return zero, error follows
    // the ack; the APB transfer lasts setup + request cycle + ack delay + response cycle.
    // An unacknowledged request ends TO cycles after the request with an error and no data.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.dly < 0) begin
            r.x_pr  = '0;
            r.x_err = 1'b1;
            r.x_cyc = TO + 2;
        end else begin
            r.x_pr  = v.wr ? '0 : v.rd;
            r.x_err = v.e;
            r.x_cyc = v.dly + 3;
        end
        return r;
    endfunction

    task automatic idle(input string tag);
        @(posedge clk); #1;
        psel = 1'b0;
        penable = 1'b0;
        ack_vld = 1'b0;
        chk({tag, "_idle_clear"}, 64'({pready, pslverr, prdata, req_vld}), 64'd0);
    endtask

    task automatic xfer(input vec_t v, input string tag);
        int            k;
        int            req_n;
        int            bad;
        logic          done;
        logic [DW-1:0] got_pr;
        logic          got_err;
        k = 0; req_n = 0; bad = 0; done = 1'b0; got_pr = '0; got_err = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_setup_clear"}, 64'({pready, pslverr, prdata, req_vld}), 64'd0);
        psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.a; pwdata = v.wd;
        ack_vld = 1'b0; rd_data = DW'($urandom); err = 1'($urandom);
        while (!done && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (v.drop && k >= 2) begin
                psel = 1'b0;
                penable = 1'b0;
            end else penable = 1'b1;
            if (req_vld) req_n++;
            if (pready) begin
                done = 1'b1;
                got_pr = prdata;
                got_err = pslverr;
                if (req_vld || wr_en || rd_en || addr != '0 || wr_data != '0) bad++;
            end else if (req_vld !== (k == 1) || wr_en !== v.wr || rd_en !== !v.wr ||
                         addr !== v.a || wr_data !== v.wd) bad++;
            ack_vld = !done && v.dly >= 0 && k == v.dly + 1;
            rd_data = ack_vld ? v.rd : DW'($urandom);
            err     = ack_vld ? v.e : 1'($urandom);
        end
        ack_vld = 1'b0;
        chk({tag, "_completed"}, 64'(done), 64'd1);
        chk({tag, "_req_pulses"}, 64'(req_n), 64'd1);
        chk({tag, "_cmd_hold"}, 64'(bad), 64'd0);
        chk({tag, "_apb_cycles"}, 64'(k + 1), 64'(v.x_cyc));
        chk({tag, "_prdata"}, 64'(got_pr), 64'(v.x_pr));
        chk({tag, "_pslverr"}, 64'(got_err), 64'(v.x_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   n;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        ack_vld = 1'b0; rd_data = '0; err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({pready, pslverr, req_vld, wr_en, rd_en}), 64'd0);
        chk("reset_prdata", 64'(prdata), 64'd0);
        chk("reset_addr", 64'(addr), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        rst_n = 1'b1;

        //          wr    addr               wdata          dly rd_data        e     gap drop  x_prdata       x_err x_cyc
        tbl[0] = '{1'b1, 48'h1000,          32'hDEADBEEF, 0, 32'h0,        1'b0, 1, 1'b0, 32'h0,        1'b0, 3};
        tbl[1] = '{1'b0, 48'h24,            32'h0,        5, 32'hA5A50001, 1'b0, 1, 1'b0, 32'hA5A50001, 1'b0, 8};
        tbl[2] = '{1'b0, 48'h30,            32'h0,        2, 32'h12345678, 1'b1, 0, 1'b0, 32'h12345678, 1'b1, 5};
        tbl[3] = '{1'b1, 48'h10,            32'h11111111, 1, 32'hFFFFFFFF, 1'b0, 1, 1'b0, 32'h0,        1'b0, 4};
        tbl[4] = '{1'b0, 48'h14,            32'h0,        0, 32'hCAFEF00D, 1'b0, 0, 1'b0, 32'hCAFEF00D, 1'b0, 3};
        tbl[5] = '{1'b1, 48'h40,            32'h5,        3, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 32'h0,        1'b1, 6};
        tbl[6] = '{1'b0, 48'h50,            32'h0,        3, 32'h0BADF00D, 1'b0, 2, 1'b1, 32'h0BADF00D, 1'b0, 6};
        tbl[7] = '{1'b0, 48'hFFFFFFFFFFFF,  32'h0,        7, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 10};
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < tbl[i].gap; g++) idle($sformatf("vec%0d_gap", i));
            xfer(tbl[i], $sformatf("vec%0d", i));
        end

        // An access phase with no setup phase before it must not start a transfer.
        idle("nosetup_pre");
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1;
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            n += int'(req_vld);
        end
        chk("nosetup_req", 64'(n), 64'd0);
        idle("nosetup_post");

`ifdef REG_APB2NATIVE_TIMEOUT_EN
        v = '{1'b0, 48'h70, 32'h0, -1, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 0};
        xfer(model(v), "timeout");
        n = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
            ack_vld = (c == 0);
            rd_data = 32'h77777777;
            n += int'(pready) + int'(req_vld);
        end
        ack_vld = 1'b0;
        chk("late_ack_ignored", 64'(n), 64'd0);
`else
        v = '{1'b0, 48'h70, 32'h0, 40, 32'h600DCAFE, 1'b0, 0, 1'b0, 32'h0, 1'b0, 0};
        xfer(model(v), "long_wait");
`endif

        for (int i = 0; i < 40; i++) begin
            v.wr   = 1'($urandom);
            v.a    = {16'($urandom), 32'($urandom)};
            v.wd   = $urandom;
            v.dly  = int'($urandom_range(0, 7));
            v.rd   = $urandom;
            v.e    = 1'($urandom);
            v.gap  = int'($urandom_range(0, 2));
            v.drop = ($urandom_range(0, 3) == 0);
            for (int g = 0; g < v.gap; g++) idle($sformatf("rnd%0d_gap", i));
            xfer(model(v), $sformatf("rnd%0d", i));
        end

        // Reset while waiting for the ack drops the transaction.
        idle("rst_pre");
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 48'h60;
        repeat (3) begin
            @(posedge clk); #1;
            penable = 1'b1;
            ack_vld = 1'b0;
        end
        chk("wait_rd_en_held", 64'({rd_en, wr_en, req_vld}), 64'h4);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({pready, pslverr, req_vld, wr_en, rd_en}), 64'd0);
        chk("midrst_prdata", 64'(prdata), 64'd0);
        chk("midrst_addr", 64'(addr), 64'd0);
        chk("midrst_wr_data", 64'(wr_data), 64'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        v = '{1'b1, 48'h20, 32'hC0FFEE00, 1, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 0};
        xfer(model(v), "after_rst");
        idle("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
